// File: rtl/load_store_sequencer.sv
// Load/store sequencer: turns one RISC-V memory op into one or two
// word-aligned bus beats, merging and extending split load data.
module load_store_sequencer #(
    parameter int REG_WIDTH_IN_BYTE = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_write,
    input  logic [2:0]                   req_funct3,
    input  logic [31:0]                  req_addr,
    input  logic [31:0]                  req_wdata,
    output logic                         resp_valid,
    output logic [31:0]                  resp_rdata,
    output logic                         resp_err,
    output logic                         mem_req,
    input  logic                         mem_gnt,
    output logic                         mem_we,
    output logic [31:0]                  mem_addr,
    output logic [REG_WIDTH_IN_BYTE-1:0] mem_be,
    output logic [31:0]                  mem_wdata,
    input  logic                         mem_rvalid,
    input  logic [31:0]                  mem_rdata
);

    typedef enum logic [2:0] {
        IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP
    } state_t;

    state_t      state_q, state_d;
    logic        op_write_q;
    logic [2:0]  op_f3_q;
    logic [31:0] op_addr_q, op_wdata_q;
    logic [63:0] rbuf_q, rbuf_d;

    logic        cur_write;
    logic [2:0]  cur_f3;
    logic [31:0] cur_addr, cur_wdata;
    logic        illegal, split;
    logic [1:0]  off;
    logic [3:0]  mask;
    logic [7:0]  be_wide;
    logic [63:0] wd_wide, shifted;
    logic [31:0] word, raw, ext;

    logic                         req_ready_d, resp_valid_d, resp_err_d;
    logic [31:0]                  resp_rdata_d;
    logic                         mem_req_d, mem_we_d;
    logic [31:0]                  mem_addr_d, mem_wdata_d;
    logic [REG_WIDTH_IN_BYTE-1:0] mem_be_d;

    // In IDLE the operands come straight from the request port.
    always_comb begin
        cur_write = op_write_q;
        cur_f3    = op_f3_q;
        cur_addr  = op_addr_q;
        cur_wdata = op_wdata_q;
        if (state_q == IDLE) begin
            cur_write = req_write;
            cur_f3    = req_funct3;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
        end
    end

    always_comb begin
        mask = 4'b1111;
        unique case (1'b1)
            (cur_f3[1:0] == 2'b00): mask = 4'b0001;
            (cur_f3[1:0] == 2'b01): mask = 4'b0011;
            default:                mask = 4'b1111;
        endcase
    end

    assign illegal = cur_write ? (cur_f3[2] | (cur_f3[1:0] == 2'b11))
                               : ((cur_f3[1:0] == 2'b11) | (cur_f3 == 3'b110));
    assign off     = cur_addr[1:0];
    assign be_wide = {4'b0000, mask} << off;
    assign wd_wide = {32'h0, cur_wdata} << {off, 3'b000};
    assign split   = |be_wide[7:4];
    assign word    = {cur_addr[31:2], 2'b00};

    // Beat 0 fills the low word, beat 1 the high word; shift out the offset.
    always_comb begin
        rbuf_d = rbuf_q;
        if (state_q == WAIT0 && mem_rvalid) rbuf_d[31:0]  = mem_rdata;
        if (state_q == WAIT1 && mem_rvalid) rbuf_d[63:32] = mem_rdata;
    end

    assign shifted = rbuf_d >> {off, 3'b000};
    assign raw     = shifted[31:0];

    always_comb begin
        ext = raw;
        unique case (cur_f3)
            3'b000:  ext = {{24{raw[7]}}, raw[7:0]};
            3'b001:  ext = {{16{raw[15]}}, raw[15:0]};
            3'b100:  ext = {24'h0, raw[7:0]};
            3'b101:  ext = {16'h0, raw[15:0]};
            default: ext = raw;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req_valid) state_d = illegal ? RESP : ISSUE0;
            ISSUE0:  if (mem_gnt) state_d = WAIT0;
            WAIT0:   if (mem_rvalid) state_d = split ? ISSUE1 : RESP;
            ISSUE1:  if (mem_gnt) state_d = WAIT1;
            WAIT1:   if (mem_rvalid) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_d  = (state_d == IDLE);
        mem_req_d    = (state_d == ISSUE0) || (state_d == ISSUE1);
        mem_we_d     = mem_we;
        mem_addr_d   = mem_addr;
        mem_be_d     = mem_be;
        mem_wdata_d  = mem_wdata;
        resp_valid_d = (state_d == RESP);
        resp_err_d   = (state_d == RESP) && illegal;
        resp_rdata_d = 32'h0;
        if (state_d == RESP && !illegal && !cur_write) resp_rdata_d = ext;
        if (state_q == IDLE && state_d == ISSUE0) begin
            mem_we_d    = cur_write;
            mem_addr_d  = word;
            mem_be_d    = be_wide[3:0];
            mem_wdata_d = wd_wide[31:0];
        end
        if (state_q == WAIT0 && state_d == ISSUE1) begin
            mem_addr_d  = word + 32'd4;
            mem_be_d    = be_wide[7:4];
            mem_wdata_d = wd_wide[63:32];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_write_q <= 1'b0;
            op_f3_q    <= 3'b000;
            op_addr_q  <= 32'h0;
            op_wdata_q <= 32'h0;
            rbuf_q     <= 64'h0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'h0;
            mem_be     <= '0;
            mem_wdata  <= 32'h0;
        end else begin
            state_q <= state_d;
            rbuf_q  <= rbuf_d;
            if (state_q == IDLE && req_valid) begin
                op_write_q <= req_write;
                op_f3_q    <= req_funct3;
                op_addr_q  <= req_addr;
                op_wdata_q <= req_wdata;
            end
            req_ready  <= req_ready_d;
            resp_valid <= resp_valid_d;
            resp_err   <= resp_err_d;
            resp_rdata <= resp_rdata_d;
            mem_req    <= mem_req_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_be     <= mem_be_d;
            mem_wdata  <= mem_wdata_d;
        end
    end

endmodule

// File: doc/load_store_sequencer.md
LOAD_STORE_SEQUENCER -- requirements
Module: load_store_sequencer

Interface
REQ-001 Parameter: REG_WIDTH_IN_BYTE, 4, register/bus width in bytes (only 4 supported).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  pipeline presents a memory operation.
REQ-005 req_ready  output  1  sequencer accepts operation this cycle.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 resp_valid  output  1  one-cycle completion pulse.
REQ-011 resp_rdata  output  32  extended load result; 0 for stores and errors.
REQ-012 resp_err  output  1  illegal funct3; valid with resp_valid.
REQ-013 mem_req  output  1  bus request.
REQ-014 mem_gnt  input  1  bus accepts request this cycle.
REQ-015 mem_we  output  1  bus write.
REQ-016 mem_addr  output  32  word-aligned address (bits [1:0] = 0).
REQ-017 mem_be  output  4  byte enables.
REQ-018 mem_wdata  output  32  lane-aligned store data.
REQ-019 mem_rvalid  input  1  bus completion (read data or write ack).
REQ-020 mem_rdata  input  32  bus read data.

Function
REQ-021 FSM states IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP; all outputs registered.
REQ-022 req_ready = 1 only in IDLE; handshake at req_valid & req_ready latches write, funct3, addr, wdata; IDLE -> ISSUE0.
REQ-023 Illegal funct3 (load 011/110/111; store 011-111): IDLE -> RESP, no bus access, resp_err = 1, resp_rdata = 0.
REQ-024 Size: byte 1, half 2, word 4; offset = addr[1:0]; split when offset + size > 4.
REQ-025 ISSUE0: mem_req = 1, mem_addr = {addr[31:2],2'b00}, mem_be = (size mask << offset)[3:0], mem_wdata = wdata << 8*offset; held stable until mem_gnt; gnt -> WAIT0.
REQ-026 ISSUE1 (split only): mem_addr = word address + 4 (32-bit wrap), mem_be = size mask >> (4 - offset), mem_wdata = wdata >> 8*(4 - offset); gnt -> WAIT1.
REQ-027 mem_rvalid sampled only in WAIT0/WAIT1; WAIT0 -> ISSUE1 if split else RESP; WAIT1 -> RESP.
REQ-028 Load assembly: beat0 bytes offset..3 -> result low bytes; beat1 bytes 0..(offset+size-5) -> next bytes.
REQ-029 Extension: LB sign from bit 7, LH sign from bit 15, LBU/LHU zero-fill, LW unchanged.
REQ-030 RESP: resp_valid = 1 exactly one cycle, no backpressure; RESP -> IDLE.
REQ-031 Minimum latency, aligned, gnt immediate, rvalid next cycle: accept at T, mem_req at T+1, rvalid at T+2, resp_valid at T+3; split adds 2 cycles.
REQ-032 mem_rvalid outside WAIT0/WAIT1 and mem_gnt outside ISSUE states are ignored.

Reset
REQ-033 rst_n low: immediate IDLE; req_ready = 1, resp_valid = 0, resp_err = 0, resp_rdata = 0, mem_req = 0, mem_we = 0, mem_addr = 0, mem_be = 0, mem_wdata = 0.
REQ-034 Reset mid-transaction abandons it; no resp_valid; late mem_rvalid after reset is ignored.

Verification
REQ-035 LB addr 0x103, mem_rdata 0x80FF_0000 -> mem_addr 0x100, mem_be 4'b1000, resp_rdata 0xFFFF_FF80 at T+3.
REQ-036 SH addr 0x202, wdata 0x0000_BEEF -> mem_we 1, mem_be 4'b1100, mem_wdata 0xBEEF_0000, resp_rdata 0.
REQ-037 LW addr 0x301, beat0 rdata 0xDDCC_BBAA, beat1 rdata 0x4433_2211 -> addrs 0x300 then 0x304, be 1110 then 0001, resp_rdata 0x11DD_CCBB.
REQ-038 mem_gnt held low 3 cycles in ISSUE0 -> mem_req/addr/be/wdata stable; req_ready 0 throughout.
REQ-039 Load funct3 3'b110 -> no mem_req, resp_valid with resp_err 1, resp_rdata 0.
REQ-040 rst_n low in WAIT0, rvalid next cycle -> no resp_valid; next request completes normally.
